kernel_launch_ctrl: RTL and testbench

- Sequences computational kernels on the multi-dataflow coprocessor.
- Queues launch requests (kernel IDs) from the host-side register interface.
- For each request, drives a configuration select, then drives kernelID to the start network. kernelID is nonzero exactly while the kernel runs.
- Waits for network completion, then reports cycle count and interrupt to the host.

---
 rtl/kernel_launch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_kernel_launch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_launch_ctrl.sv
// rtl/kernel_launch_ctrl.sv - kernel launch sequencer with request FIFO
//
// Queues kernel launch requests from the host, selects the datapath
// configuration for each one, starts it on the network, waits for completion
// and reports ID, run-cycle count and abort status with a one-cycle irq.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_id/valid/ready    launch request handshake (ID 0 is consumed and dropped)
//   abort                 abort current kernel (honoured in SETUP and RUN)
//   done                  completion from the network (honoured in RUN only)
//   sel_id                configuration select, cur_id in SETUP and RUN
//   kernelID              start level, cur_id in RUN, 0 otherwise
//   busy, pending         FSM not idle, FIFO occupancy
//   irq                   one-cycle pulse in DONE
//   last_id/cycles/aborted  result of the most recently finished kernel
module kernel_launch_ctrl #(
  parameter int SIZEID     = 8,
  parameter int DEPTH      = 4,
  parameter int CFG_CYCLES = 2,
  parameter int CNTW       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [SIZEID-1:0]        req_id,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     abort,
  input  logic                     done,
  output logic [SIZEID-1:0]        sel_id,
  output logic [SIZEID-1:0]        kernelID,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     irq,
  output logic [SIZEID-1:0]        last_id,
  output logic [CNTW-1:0]          last_cycles,
  output logic                     last_aborted
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(CFG_CYCLES + 1);
  localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
  localparam logic [SW-1:0] SETUP_LAST = SW'(CFG_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [SIZEID-1:0] fifo_mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [SIZEID-1:0] cur_id_q, cur_id_d;
  logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
  logic [CNTW-1:0]   run_cnt_q, run_cnt_d;
  logic [SIZEID-1:0] last_id_q, last_id_d;
  logic [CNTW-1:0]   last_cycles_q, last_cycles_d;
  logic              last_aborted_q, last_aborted_d;
  logic [SIZEID-1:0] sel_id_q, sel_id_d, kernel_id_q, kernel_id_d;
  logic              irq_q, irq_d, busy_q, busy_d, req_ready_q, req_ready_d;
  logic              push, pop;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  // req_ready_q always mirrors !full of count_q, so a full FIFO refuses a
  // request even when a pop happens on the same edge. Zero IDs complete the
  // handshake but are never written.
  assign push = req_valid && req_ready_q && (req_id != '0);

  always_comb begin
    state_d        = state_q;
    cur_id_d       = cur_id_q;
    setup_cnt_d    = setup_cnt_q;
    run_cnt_d      = run_cnt_q;
    last_id_d      = last_id_q;
    last_cycles_d  = last_cycles_q;
    last_aborted_d = last_aborted_q;
    pop            = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          cur_id_d    = fifo_mem[rd_ptr_q];
          setup_cnt_d = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d        = DONE;
          last_id_d      = cur_id_q;
          last_cycles_d  = '0;
          last_aborted_d = 1'b1;
        end else if (setup_cnt_q == SETUP_LAST) begin
          state_d   = RUN;
          run_cnt_d = '0;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      RUN: begin
        // The sampling cycle of done/abort is itself a RUN cycle.
        run_cnt_d = sat_inc(run_cnt_q);
        if (done || abort) begin
          state_d        = DONE;
          last_id_d      = cur_id_q;
          last_cycles_d  = sat_inc(run_cnt_q);
          last_aborted_d = !done;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    sel_id_d    = (state_d == SETUP || state_d == RUN) ? cur_id_d : '0;
    kernel_id_d = (state_d == RUN) ? cur_id_d : '0;
    irq_d       = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    req_ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= req_id;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      cur_id_q       <= '0;
      setup_cnt_q    <= '0;
      run_cnt_q      <= '0;
      last_id_q      <= '0;
      last_cycles_q  <= '0;
      last_aborted_q <= 1'b0;
      sel_id_q       <= '0;
      kernel_id_q    <= '0;
      irq_q          <= 1'b0;
      busy_q         <= 1'b0;
      req_ready_q    <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      cur_id_q       <= cur_id_d;
      setup_cnt_q    <= setup_cnt_d;
      run_cnt_q      <= run_cnt_d;
      last_id_q      <= last_id_d;
      last_cycles_q  <= last_cycles_d;
      last_aborted_q <= last_aborted_d;
      sel_id_q       <= sel_id_d;
      kernel_id_q    <= kernel_id_d;
      irq_q          <= irq_d;
      busy_q         <= busy_d;
      req_ready_q    <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign sel_id       = sel_id_q;
  assign kernelID     = kernel_id_q;
  assign busy         = busy_q;
  assign pending      = count_q;
  assign irq          = irq_q;
  assign last_id      = last_id_q;
  assign last_cycles  = last_cycles_q;
  assign last_aborted = last_aborted_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// tb/tb_kernel_launch_ctrl.sv - directed bench for kernel_launch_ctrl
module tb_kernel_launch_ctrl;

  logic       clock, reset;
  logic [7:0] req_id;
  logic       req_valid, req_ready, abort, done;
  logic [7:0] sel_id, kernelID, last_id;
  logic       busy, irq, last_aborted;
  logic [2:0] pending;
  logic [3:0] last_cycles;

  int checks = 0;
  int errors = 0;

  kernel_launch_ctrl #(.SIZEID(8), .DEPTH(4), .CFG_CYCLES(2), .CNTW(4)) dut (
    .clock(clock), .reset(reset), .req_id(req_id), .req_valid(req_valid),
    .req_ready(req_ready), .abort(abort), .done(done), .sel_id(sel_id),
    .kernelID(kernelID), .busy(busy), .pending(pending), .irq(irq),
    .last_id(last_id), .last_cycles(last_cycles), .last_aborted(last_aborted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // mode: 0 done at run cycle n, 1 abort in 1st SETUP cycle,
  //       2 abort at run cycle n, 3 done+abort at run cycle n,
  //       4 done held during SETUP then done at run cycle n
  typedef struct {
    logic [7:0] id;
    int         mode;
    int         n;
    int         exp_sel;
    int         exp_kid;
    int         exp_cyc;
    int         exp_ab;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Launch one kernel from idle and follow it to its irq.
  task automatic run_launch(input vec_t v, input string tag);
    int sc, kc, rc, ssc;
    bit seen;
    sc = 0; kc = 0; rc = 0; ssc = 0; seen = 0;
    req_id = v.id;
    req_valid = 1'b1;
    for (int c = 0; c < 100 && !seen; c++) begin
      step();
      req_valid = 1'b0;
      done = 1'b0;
      abort = 1'b0;
      if (irq) begin
        seen = 1;
        chk({tag, "_last_id"}, last_id, v.id);
        chk({tag, "_last_cycles"}, last_cycles, v.exp_cyc);
        chk({tag, "_last_aborted"}, last_aborted, v.exp_ab);
      end else begin
        if (sel_id == v.id) sc++;
        if (kernelID == v.id) begin
          kc++;
          rc++;
          if (rc == v.n) begin
            if (v.mode == 0 || v.mode == 3 || v.mode == 4) done = 1'b1;
            if (v.mode == 2 || v.mode == 3) abort = 1'b1;
          end
        end else if (sel_id == v.id) begin
          ssc++;
          if (v.mode == 1 && ssc == 1) abort = 1'b1;
          if (v.mode == 4) done = 1'b1;
        end
      end
    end
    chk({tag, "_irq_seen"}, seen, 1);
    chk({tag, "_sel_cycles"}, sc, v.exp_sel);
    chk({tag, "_kid_cycles"}, kc, v.exp_kid);
    step();
    chk({tag, "_irq_one_cycle"}, irq, 0);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  // Push a list back-to-back, holding each ID until it is accepted.
  task automatic push_ids(input logic [7:0] q[$], output int pushed);
    logic rr;
    pushed = 0;
    req_valid = 1'b1;
    req_id = q[0];
    for (int c = 0; c < 40 && pushed < q.size(); c++) begin
      rr = req_ready;
      step();
      if (rr) pushed++;
      if (pushed < q.size()) req_id = q[pushed];
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int pushed, ng, zc, min_gap, irqs;
    logic [7:0] prev_k;
    logic [7:0] got[5];
    logic [7:0] fill_q[$];

    vecs[0] = '{8'd5,   0, 3,  5,  3,  3, 0};
    vecs[1] = '{8'hA5,  0, 1,  3,  1,  1, 0};
    vecs[2] = '{8'd12,  1, 0,  1,  0,  0, 1};
    vecs[3] = '{8'd200, 2, 4,  6,  4,  4, 1};
    vecs[4] = '{8'd3,   3, 2,  4,  2,  2, 0};
    vecs[5] = '{8'd255, 0, 20, 22, 20, 15, 0};
    vecs[6] = '{8'd9,   0, 14, 16, 14, 14, 0};
    vecs[7] = '{8'd6,   4, 2,  4,  2,  2, 0};

    reset = 1'b1; req_id = 8'd0; req_valid = 1'b0; abort = 1'b0; done = 1'b0;
    #2;
    chk("rst_sel_id", sel_id, 0);
    chk("rst_kernelID", kernelID, 0);
    chk("rst_pending", pending, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_last", {last_id, last_cycles, 3'b0, last_aborted}, 0);
    step();
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_launch(vecs[i], $sformatf("vec%0d", i));

    // Queue fill: 1 goes straight to SETUP, 2,3,4,6 fill the FIFO.
    fill_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
    push_ids(fill_q, pushed);
    chk("fill_pushed", pushed, 5);
    req_id = 8'd11;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("fill_stall_ready", req_ready, 0);
      chk("fill_stall_pending", pending, 4);
    end
    req_valid = 1'b0;
    ng = 0; zc = 0; min_gap = 1000; prev_k = kernelID;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      step();
      done = (kernelID != 0);
      if (irq) begin
        got[ng] = last_id;
        ng++;
      end
      if (kernelID != 0 && prev_k == 0 && zc < min_gap) min_gap = zc;
      zc = (kernelID == 0) ? zc + 1 : 0;
      prev_k = kernelID;
    end
    done = 1'b0;
    chk("fill_irq_count", ng, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("fill_order%0d", i), got[i], fill_q[i]);
    chk("fill_min_gap_ge2", int'(min_gap >= 2), 1);
    step();
    chk("fill_drained_pending", pending, 0);

    // Zero ID is consumed without being queued.
    req_id = 8'd0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("zero_pending", pending, 0);
    step();
    chk("zero_not_busy", busy, 0);
    run_launch('{8'd7, 0, 2, 4, 2, 2, 0}, "zero_then7");
    irqs = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      irqs += irq;
    end
    chk("zero_no_extra_irq", irqs, 0);

    // Asynchronous reset while kernel 9 runs with two requests queued.
    fill_q = '{8'd9, 8'd13, 8'd14};
    push_ids(fill_q, pushed);
    chk("rstrun_pushed", pushed, 3);
    for (int c = 0; c < 20 && kernelID != 8'd9; c++) step();
    chk("rstrun_running", kernelID, 9);
    chk("rstrun_queued", pending, 2);
    reset = 1'b1;
    #1;
    chk("rstrun_kernelID", kernelID, 0);
    chk("rstrun_pending", pending, 0);
    chk("rstrun_sel_id", sel_id, 0);
    chk("rstrun_busy", busy, 0);
    step();
    reset = 1'b0;
    irqs = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      irqs += irq;
      irqs += busy;
    end
    chk("rstrun_no_irq_no_busy", irqs, 0);
    run_launch('{8'd21, 0, 2, 4, 2, 2, 0}, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
